// File: rtl/uart_rx_cmd_collector_pkg.sv
// Shared definitions for the Bluetooth UART receive path: bit-FSM states, default widths and
// the idle line level.
package uart_rx_cmd_collector_pkg;

  localparam int unsigned DefCntW     = 10;
  localparam int unsigned DefMaxBytes = 4;
  localparam int unsigned LenW        = 3;
  localparam logic        LineIdle    = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_cmd_collector_byte.sv
// UART byte receiver: 2-flop synchroniser, start-edge detect and the start/data/stop bit FSM.
// bit_tick also free-runs at the live bit rate while idle so the packet spacing timer can use it.
module uart_rx_cmd_collector_byte
  import uart_rx_cmd_collector_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_line,
  input  logic             link_up,
  input  logic [CNT_W-1:0] uart_cpd,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_ferr,
  output logic             busy,
  output logic             bit_tick
);

  logic             sync1_q, sync2_q, prev_q;
  logic             fall_edge;
  logic [CNT_W-1:0] cpd_live;
  logic             half_end, bit_end;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cpd_q, cpd_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;

  assign cpd_live  = (uart_cpd < CNT_W'(2)) ? CNT_W'(2) : uart_cpd;
  assign fall_edge = prev_q & ~sync2_q;
  assign half_end  = timer_q >= ((cpd_q >> 1) - CNT_W'(1));
  assign bit_end   = timer_q >= (cpd_q - CNT_W'(1));

  assign busy      = (state_q != StIdle);
  assign byte_data = shift_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= LineIdle;
      sync2_q   <= LineIdle;
      prev_q    <= LineIdle;
      state_q   <= StIdle;
      timer_q   <= '0;
      cpd_q     <= CNT_W'(2);
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      sync1_q   <= rx_line;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      cpd_q     <= cpd_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + CNT_W'(1);
    cpd_d      = cpd_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    byte_ferr  = 1'b0;
    bit_tick   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (timer_q >= (cpd_live - CNT_W'(1))) begin
          bit_tick = 1'b1;
          timer_d  = '0;
        end
        // Bit period is frozen here so a mid-byte uart_cpd change waits for the next start bit.
        if (fall_edge) begin
          state_d = StStart;
          timer_d = '0;
          cpd_d   = cpd_live;
        end
      end
      StStart: begin
        if (half_end) begin
          bit_tick  = 1'b1;
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = (sync2_q == LineIdle) ? StIdle : StData;
        end
      end
      StData: begin
        if (bit_end) begin
          bit_tick  = 1'b1;
          timer_d   = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          bit_tick   = 1'b1;
          timer_d    = '0;
          state_d    = StIdle;
          byte_valid = (sync2_q == LineIdle);
          byte_ferr  = (sync2_q != LineIdle);
        end
      end
    endcase

    if (!link_up) begin
      state_d    = StIdle;
      byte_valid = 1'b0;
      byte_ferr  = 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_cmd_collector.sv
// Bluetooth UART receive command collector: groups received bytes into packets closed either by
// reaching MAX_BYTES or by an idle gap of uart_byte_spacing_limit bit periods.
module uart_rx_cmd_collector
  import uart_rx_cmd_collector_pkg::*;
#(
  parameter int unsigned MAX_BYTES = DefMaxBytes,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rx_line,
  input  logic                   link_up,
  input  logic [CNT_W-1:0]       uart_cpd,
  input  logic [CNT_W-1:0]       uart_byte_spacing_limit,
  output logic                   cmd_valid,
  output logic [MAX_BYTES*8-1:0] cmd_data,
  output logic [LenW-1:0]        cmd_len,
  output logic                   frame_err,
  output logic                   rx_busy
);

  localparam logic [LenW-1:0] LastIdx = LenW'(MAX_BYTES - 1);

  logic       byte_valid, byte_ferr, busy, bit_tick;
  logic [7:0] byte_data;

  logic [LenW-1:0]        count_q, count_d;
  logic [MAX_BYTES*8-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]       spacing_q, spacing_d;
  logic                   close;
  logic [LenW-1:0]        close_len;
  logic [MAX_BYTES*8-1:0] close_data;
  logic                   ferr_d;

  logic                   cmd_valid_q;
  logic [MAX_BYTES*8-1:0] cmd_data_q;
  logic [LenW-1:0]        cmd_len_q;
  logic                   frame_err_q;

  uart_rx_cmd_collector_byte #(
    .CNT_W(CNT_W)
  ) u_rx_byte (
    .clk       (clk),
    .resetn    (resetn),
    .rx_line   (rx_line),
    .link_up   (link_up),
    .uart_cpd  (uart_cpd),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ferr (byte_ferr),
    .busy      (busy),
    .bit_tick  (bit_tick)
  );

  always_comb begin
    count_d    = count_q;
    slots_d    = slots_q;
    spacing_d  = spacing_q;
    close      = 1'b0;
    close_len  = count_q;
    close_data = slots_q;
    ferr_d     = 1'b0;

    if (busy || count_q == '0) begin
      spacing_d = '0;
    end else if (bit_tick && spacing_q != '1) begin
      spacing_d = spacing_q + CNT_W'(1);
    end

    if (!link_up) begin
      count_d   = '0;
      slots_d   = '0;
      spacing_d = '0;
    end else if (byte_ferr) begin
      count_d = '0;
      slots_d = '0;
      ferr_d  = 1'b1;
    end else if (byte_valid) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        if (count_q == LenW'(i)) slots_d[i*8 +: 8] = byte_data;
      end
      spacing_d = '0;
      if (count_q == LastIdx) begin
        close      = 1'b1;
        close_len  = count_q + LenW'(1);
        close_data = slots_d;
        count_d    = '0;
        slots_d    = '0;
      end else begin
        count_d = count_q + LenW'(1);
      end
    end else if (!busy && count_q != '0 && spacing_q >= uart_byte_spacing_limit) begin
      // busy is still low on the start-edge cycle, so a simultaneous edge loses to the close.
      close     = 1'b1;
      count_d   = '0;
      slots_d   = '0;
      spacing_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q     <= '0;
      slots_q     <= '0;
      spacing_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      cmd_len_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      slots_q     <= slots_d;
      spacing_q   <= spacing_d;
      cmd_valid_q <= close;
      frame_err_q <= ferr_d;
      if (close) begin
        cmd_data_q <= close_data;
        cmd_len_q  <= close_len;
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_len   = cmd_len_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = busy;

endmodule
